// File: rtl/reverb_fft_pkg.sv
// Shared widths, defaults and helpers for the reverb FFT framing path.
package reverb_fft_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int WORD_W            = 32;
    localparam int FRAME_LEN_DEFAULT = 512;
    localparam int WORD_BUF_DEPTH    = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reverb_st_word_buffer.sv
// Small register FIFO holding packed sample words ahead of the unpacker.
module reverb_st_word_buffer
    import reverb_fft_pkg::*;
#(
    parameter int DEPTH = WORD_BUF_DEPTH,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              pop,
    output logic [WORD_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              drop
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~clear;
    // A full buffer still takes a word when the head leaves in the same cycle.
    assign drop    = push & ~clear & full & ~do_pop;
    assign do_push = push & ~clear & ~drop;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reverb_fft_frame_unpacker.sv
// Splits packed 2x16-bit words into single-sample beats and frames them
// into FFT blocks with sop/eop markers.
module reverb_fft_frame_unpacker
    import reverb_fft_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int BUF_DEPTH = WORD_BUF_DEPTH
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [WORD_W-1:0]   sink_data,
    input  logic                sink_valid,
    output logic                sink_ready,
    output logic [SAMPLE_W-1:0] src_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic                src_sop,
    output logic                src_eop,
    output logic                frame_done,
    output logic                overflow
);

    localparam int CNT_W  = clog2(FRAME_LEN);
    localparam int BCNT_W = clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [BCNT_W-1:0] READY_MAX = BCNT_W'(BUF_DEPTH - 2);

    logic [WORD_W-1:0] head;
    logic [BCNT_W-1:0] count;
    logic              empty;
    logic              drop;
    logic              pop;
    logic              load;
    logic              accept;
    logic              half_sel;
    logic              ready_en;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  load_idx;
    sample_t           head_sample;

    reverb_st_word_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (sink_valid),
        .wr_data (sink_data),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .empty   (empty),
        .drop    (drop)
    );

    // Two words of slack cover the word already in flight under ready latency 1.
    assign sink_ready = ready_en & (count <= READY_MAX);

    assign accept      = src_valid & src_ready;
    assign load        = (~src_valid | src_ready) & ~empty & ~clear;
    assign pop         = load & half_sel;
    assign head_sample = half_sel ? sample_t'(head[WORD_W-1:SAMPLE_W])
                                  : sample_t'(head[SAMPLE_W-1:0]);

    assign cnt_inc  = (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
    // cnt indexes the beat sitting in the output register; a beat leaving
    // in the same cycle makes the incoming one its successor.
    assign load_idx = accept ? cnt_inc : cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            half_sel   <= 1'b0;
            cnt        <= '0;
            src_valid  <= 1'b0;
            src_data   <= '0;
            src_sop    <= 1'b0;
            src_eop    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            half_sel   <= 1'b0;
            cnt        <= '0;
            src_valid  <= 1'b0;
            src_sop    <= 1'b0;
            src_eop    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= accept & src_eop;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                cnt <= cnt_inc;
            end
            if (load) begin
                src_valid <= 1'b1;
                src_data  <= head_sample;
                src_sop   <= (load_idx == '0);
                src_eop   <= (load_idx == LAST_IDX);
                half_sel  <= ~half_sel;
            end else if (~src_valid | src_ready) begin
                src_valid <= 1'b0;
                src_sop   <= 1'b0;
                src_eop   <= 1'b0;
            end
        end
    end

endmodule
